// File: rtl/multi_linebuffer.sv
// Ring of C_LINES line RAMs: one line is written at a time, and two vertically adjacent
// committed lines are read in the same column in one access.
module multi_linebuffer #(
  parameter int unsigned C_DATA_WIDTH    = 8,
  parameter int unsigned C_ADDRESS_WIDTH = 11,
  parameter int unsigned C_LINES         = 4,
  parameter int unsigned C_CNT_WIDTH     = $clog2(C_LINES + 1)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [C_ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [C_DATA_WIDTH-1:0]    wr_data,
  input  logic                       wr_eol,
  output logic                       wr_ready,
  input  logic                       rd_en,
  input  logic [C_ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [C_CNT_WIDTH-1:0]     rd_base,
  output logic [C_DATA_WIDTH-1:0]    rd_data0,
  output logic [C_DATA_WIDTH-1:0]    rd_data1,
  output logic                       rd_valid,
  input  logic                       rd_release,
  output logic [C_CNT_WIDTH-1:0]     lines_avail,
  output logic                       empty
);

  localparam int unsigned Depth = 2 ** C_ADDRESS_WIDTH;

  typedef logic [C_CNT_WIDTH-1:0] cnt_t;
  typedef logic [C_CNT_WIDTH:0]   sum_t;

  function automatic cnt_t inc_wrap(input cnt_t v);
    return (v == cnt_t'(C_LINES - 1)) ? '0 : v + cnt_t'(1);
  endfunction

  cnt_t wr_line_q, wr_line_d;
  cnt_t rd_line_q, rd_line_d;
  cnt_t count_q, count_d;
  cnt_t sel0_q, sel0_d;
  cnt_t sel1_q, sel1_d;
  logic rd_valid_q, rd_valid_d;
  logic zero_q, zero_d;

  logic wr_fire, commit, rel, rd_fire, rd_legal;
  sum_t sum0;
  cnt_t l0, l1;

  logic [C_DATA_WIDTH-1:0] line_rdata [C_LINES];

  assign wr_ready    = (count_q < cnt_t'(C_LINES));
  assign empty       = (count_q == '0);
  assign lines_avail = count_q;
  assign rd_valid    = rd_valid_q;

  // clear outranks every other event in its cycle, including the read-data update
  assign wr_fire = wr_en && wr_ready && !clear;
  assign commit  = wr_fire && wr_eol;
  assign rel     = rd_release && (count_q != '0) && !clear;
  assign rd_fire = rd_en && !clear;

  assign rd_legal = (sum_t'(rd_base) + sum_t'(2)) <= sum_t'(count_q);

  always_comb begin
    sum0 = sum_t'(rd_line_q) + sum_t'(rd_base);
    if (sum0 >= sum_t'(C_LINES)) begin
      sum0 = sum0 - sum_t'(C_LINES);
    end
    l0 = sum0[C_CNT_WIDTH-1:0];
    l1 = inc_wrap(l0);
  end

  always_comb begin
    wr_line_d  = wr_line_q;
    rd_line_d  = rd_line_q;
    count_d    = count_q;
    sel0_d     = sel0_q;
    sel1_d     = sel1_q;
    zero_d     = zero_q;
    rd_valid_d = 1'b0;
    if (clear) begin
      wr_line_d = '0;
      rd_line_d = '0;
      count_d   = '0;
    end else begin
      if (rd_fire) begin
        sel0_d     = l0;
        sel1_d     = l1;
        zero_d     = 1'b0;
        rd_valid_d = rd_legal;
      end
      if (commit) begin
        wr_line_d = inc_wrap(wr_line_q);
      end
      if (rel) begin
        rd_line_d = inc_wrap(rd_line_q);
      end
      unique case ({commit, rel})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_line_q  <= '0;
      rd_line_q  <= '0;
      count_q    <= '0;
      sel0_q     <= '0;
      sel1_q     <= '0;
      rd_valid_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      wr_line_q  <= wr_line_d;
      rd_line_q  <= rd_line_d;
      count_q    <= count_d;
      sel0_q     <= sel0_d;
      sel1_q     <= sel1_d;
      rd_valid_q <= rd_valid_d;
      zero_q     <= zero_d;
    end
  end

  // Per-line read-first RAM with an unreset output register; zero_q forces the
  // visible read data to 0 from reset until the first read lands.
  for (genvar g = 0; g < C_LINES; g++) begin : g_line
    logic [C_DATA_WIDTH-1:0] mem [Depth];
    logic [C_DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (wr_fire && (wr_line_q == cnt_t'(g))) begin
        mem[wr_addr] <= wr_data;
      end
      if (rd_fire) begin
        rdata_q <= mem[rd_addr];
      end
    end

    assign line_rdata[g] = rdata_q;
  end

  always_comb begin
    rd_data0 = '0;
    rd_data1 = '0;
    if (!zero_q) begin
      for (int i = 0; i < C_LINES; i++) begin
        if (sel0_q == cnt_t'(i)) rd_data0 = line_rdata[i];
        if (sel1_q == cnt_t'(i)) rd_data1 = line_rdata[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_linebuffer.sv
// Directed plus random bench for multi_linebuffer against a queue-free array reference model.
module tb_multi_linebuffer;

  localparam int DW = 8;
  localparam int AW = 11;
  localparam int NL = 4;
  localparam int CW = $clog2(NL + 1);
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          resetn;
  logic          clear;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_eol;
  logic          wr_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_base;
  logic [DW-1:0] rd_data0;
  logic [DW-1:0] rd_data1;
  logic          rd_valid;
  logic          rd_release;
  logic [CW-1:0] lines_avail;
  logic          empty;

  multi_linebuffer #(
    .C_DATA_WIDTH   (DW),
    .C_ADDRESS_WIDTH(AW),
    .C_LINES        (NL),
    .C_CNT_WIDTH    (CW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_eol     (wr_eol),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_base    (rd_base),
    .rd_data0   (rd_data0),
    .rd_data1   (rd_data1),
    .rd_valid   (rd_valid),
    .rd_release (rd_release),
    .lines_avail(lines_avail),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: line contents plus pointers held as plain integers.
  logic [DW-1:0] mem_m [NL][DEPTH];
  bit            kn_m  [NL][DEPTH];
  int m_wr, m_rd, m_cnt;
  int exp_d0, exp_d1, exp_v;
  bit exp_known;

  task chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task model_reset();
    m_wr = 0; m_rd = 0; m_cnt = 0;
    exp_d0 = 0; exp_d1 = 0; exp_v = 0; exp_known = 1;
  endtask

  task model_step();
    int l0, l1, commit, rel;
    if (clear) begin
      m_wr = 0; m_rd = 0; m_cnt = 0; exp_v = 0;
    end else begin
      if (rd_en) begin
        l0 = (m_rd + int'(rd_base)) % NL;
        l1 = (l0 + 1) % NL;
        exp_d0 = int'(mem_m[l0][rd_addr]);
        exp_d1 = int'(mem_m[l1][rd_addr]);
        exp_known = kn_m[l0][rd_addr] && kn_m[l1][rd_addr];
        exp_v = (int'(rd_base) + 2 <= m_cnt) ? 1 : 0;
      end else begin
        exp_v = 0;
      end
      commit = 0;
      rel = 0;
      if (wr_en && m_cnt < NL) begin
        mem_m[m_wr][wr_addr] = wr_data;
        kn_m[m_wr][wr_addr] = 1'b1;
        if (wr_eol) commit = 1;
      end
      if (rd_release && m_cnt > 0) rel = 1;
      if (commit == 1) m_wr = (m_wr + 1) % NL;
      if (rel == 1) m_rd = (m_rd + 1) % NL;
      m_cnt = m_cnt + commit - rel;
    end
  endtask

  task check_outputs();
    chk("wr_ready", int'(wr_ready), (m_cnt < NL) ? 1 : 0);
    chk("lines_avail", int'(lines_avail), m_cnt);
    chk("empty", int'(empty), (m_cnt == 0) ? 1 : 0);
    chk("rd_valid", int'(rd_valid), exp_v);
    if (exp_known) begin
      chk("rd_data0", int'(rd_data0), exp_d0);
      chk("rd_data1", int'(rd_data1), exp_d1);
    end
  endtask

  task cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task idle();
    clear = 0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_eol = 0;
    rd_en = 0; rd_addr = '0; rd_base = '0; rd_release = 0;
  endtask

  task write_line(input int base);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = DW'(base + i); wr_eol = (i == 7);
      cycle();
    end
    idle();
  endtask

  task do_read(input int base, input int addr);
    rd_en = 1; rd_base = CW'(base); rd_addr = AW'(addr);
    cycle();
    idle();
  endtask

  task do_release(input int n);
    for (int i = 0; i < n; i++) begin
      rd_release = 1;
      cycle();
    end
    idle();
  endtask

  initial begin
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < DEPTH; a++) kn_m[l][a] = 1'b0;
    idle();
    model_reset();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_data0", int'(rd_data0), 0);
    resetn = 1;

    // Fill two lines and read a column from both.
    write_line(8'h10);
    write_line(8'h20);
    do_read(0, 3);
    chk("fill_d0", int'(rd_data0), 8'h13);
    chk("fill_d1", int'(rd_data1), 8'h23);
    chk("fill_valid", int'(rd_valid), 1);
    chk("fill_avail", int'(lines_avail), 2);

    // Full: the fifth write is dropped.
    write_line(8'h30);
    write_line(8'h40);
    chk("full_ready", int'(wr_ready), 0);
    wr_en = 1; wr_addr = '0; wr_data = 8'hFF; wr_eol = 1;
    cycle();
    idle();
    do_read(2, 0);
    chk("full_d1", int'(rd_data1), 8'h40);
    chk("full_avail", int'(lines_avail), 4);

    // Wrap and release.
    do_release(2);
    write_line(8'h50);
    write_line(8'h60);
    do_read(2, 1);
    chk("wrap_d0", int'(rd_data0), 8'h51);
    chk("wrap_d1", int'(rd_data1), 8'h61);

    // Commit and release in the same cycle at count=3.
    do_release(1);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = DW'(8'h70 + i); wr_eol = (i == 7);
      rd_release = (i == 7);
      cycle();
    end
    idle();
    chk("simul_avail", int'(lines_avail), 3);
    do_read(0, 0);
    chk("simul_d0", int'(rd_data0), 8'h50);
    chk("simul_d1", int'(rd_data1), 8'h60);
    do_read(1, 0);
    chk("simul_d1b", int'(rd_data1), 8'h70);

    // Release on empty is ignored.
    do_release(3);
    do_release(1);
    chk("rel_empty", int'(empty), 1);

    // Illegal read, then clear beats a committing write.
    write_line(8'h80);
    do_read(0, 0);
    chk("illegal_valid", int'(rd_valid), 0);
    clear = 1; wr_en = 1; wr_eol = 1; wr_addr = AW'(9); wr_data = 8'hEE;
    cycle();
    idle();
    chk("clear_avail", int'(lines_avail), 0);
    write_line(8'h90);
    write_line(8'hA0);
    do_read(0, 0);
    chk("clear_d0", int'(rd_data0), 8'h90);
    chk("clear_d1", int'(rd_data1), 8'hA0);

    // Asynchronous reset in the middle of a line.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = DW'(8'hD0 + i); wr_eol = 0;
      cycle();
    end
    #3;
    resetn = 0;
    #1;
    idle();
    model_reset();
    chk("areset_valid", int'(rd_valid), 0);
    chk("areset_d0", int'(rd_data0), 0);
    chk("areset_d1", int'(rd_data1), 0);
    chk("areset_avail", int'(lines_avail), 0);
    @(posedge clk);
    #1;
    resetn = 1;
    write_line(8'hB0);
    write_line(8'hC0);
    do_read(0, 5);
    chk("post_reset_d0", int'(rd_data0), 8'hB5);
    chk("post_reset_d1", int'(rd_data1), 8'hC5);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      clear      = ($urandom_range(0, 49) == 0);
      wr_en      = ($urandom_range(0, 9) < 7);
      wr_addr    = AW'($urandom_range(0, 15));
      wr_data    = DW'($urandom);
      wr_eol     = ($urandom_range(0, 6) == 0);
      rd_en      = ($urandom_range(0, 1) == 1);
      rd_addr    = AW'($urandom_range(0, 15));
      rd_base    = CW'($urandom_range(0, NL));
      rd_release = ($urandom_range(0, 7) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_linebuffer.md
Name: multi_linebuffer

Overview:
- Ring of C_LINES single-line RAMs for the axis_scaler vertical path.
- The writer fills one line at a time. The reader fetches the same pixel column from two vertically adjacent completed lines in one access, for vertical interpolation.
- Line occupancy is tracked internally, with end-of-line commit, release and flush control.
- Generalises the one-line buffer to N lines, dual-line reads, flow control and occupancy status.

Parameters:
- C_DATA_WIDTH, 8, pixel width in bits.
- C_ADDRESS_WIDTH, 11, pixel address width; line length up to 2**C_ADDRESS_WIDTH.
- C_LINES, 4, number of line RAMs; legal range 2..16; need not be a power of two.
- C_CNT_WIDTH, $clog2(C_LINES+1), width of the line count and rd_base.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; discards all lines and pointers.
- wr_en  in  1  write strobe.
- wr_addr  in  C_ADDRESS_WIDTH  pixel column in the current write line.
- wr_data  in  C_DATA_WIDTH  pixel to write.
- wr_eol  in  1  commits the current write line; qualified by wr_en.
- wr_ready  out  1  a free line exists to write into.
- rd_en  in  1  read strobe.
- rd_addr  in  C_ADDRESS_WIDTH  pixel column to read.
- rd_base  in  C_CNT_WIDTH  line offset from the oldest committed line.
- rd_data0  out  C_DATA_WIDTH  pixel from line (oldest+rd_base).
- rd_data1  out  C_DATA_WIDTH  pixel from line (oldest+rd_base+1).
- rd_valid  out  1  rd_data0/rd_data1 hold a valid read result.
- rd_release  in  1  frees the oldest committed line.
- lines_avail  out  C_CNT_WIDTH  number of committed lines.
- empty  out  1  lines_avail==0.

Behaviour:
- State:
  - wr_line index, 0..C_LINES-1.
  - rd_line index (oldest committed line), 0..C_LINES-1.
  - count, 0..C_LINES.
  - All index arithmetic is modulo C_LINES via compare-and-wrap, with no power-of-two masking.
- Reset (resetn low, asynchronous): wr_line=0, rd_line=0, count=0, rd_data0=0, rd_data1=0, rd_valid=0. RAM contents are not reset.
- Status outputs:
  - wr_ready = (count < C_LINES), combinational from registered count.
  - empty = (count==0).
  - lines_avail = count.
- Write:
  - When wr_en && wr_ready, RAM[wr_line][wr_addr] <= wr_data.
  - If wr_eol is also high, the pixel is written and then wr_line advances (wrap C_LINES-1 -> 0) and count increments.
  - When wr_en && !wr_ready, the write and the eol are both dropped; no state change.
- Read:
  - When rd_en, sample lines L0=(rd_line+rd_base) mod C_LINES and L1=(L0+1) mod C_LINES at rd_addr.
  - Latency is 1 cycle: rd_data0/rd_data1 are registered, and rd_valid=1 in the next cycle.
  - A read is legal only if rd_base+2 <= count. If illegal, the data registers still update with whatever the RAM holds, but rd_valid=0.
  - When !rd_en, rd_data0/rd_data1 hold their value and rd_valid=0.
- Release:
  - When rd_release && count>0, rd_line advances (wrap) and count decrements.
  - When rd_release && count==0, it is ignored.
- Simultaneous events:
  - Committing eol and a valid release in the same cycle: count unchanged, both pointers advance.
  - A read in the same cycle as a release uses the pre-release rd_line.
- Collisions:
  - RAM is read-first: reading the address being written in the same cycle returns the old data.
  - The line under write is never counted in count, so a legal read never targets it.
- clear:
  - Synchronous; highest priority over write, eol and release in the same cycle.
  - Sets wr_line=0, rd_line=0, count=0, rd_valid=0. rd_data0/rd_data1 hold their values.
  - A write in the clear cycle is dropped.
- Reset mid-line: a partially written line is lost; the pointers restart at line 0.
- Storage: one simple dual-port RAM of depth 2**C_ADDRESS_WIDTH per line, inferable as block RAM. Reads fan out through a C_LINES:1 mux on each of the two outputs.

Test Plan:
- Reset then fill: write line0 pixels 0..7 = 0x10+i with eol on pixel 7, then line1 = 0x20+i. Read rd_base=0, rd_addr=3 -> one cycle later rd_data0=0x13, rd_data1=0x23, rd_valid=1; lines_avail=2.
- Full: C_LINES=4; commit 4 lines -> wr_ready=0, lines_avail=4. A 5th write to addr 0 with data 0xFF is dropped; reading line 3 addr 0 returns its original value.
- Wrap and release: commit 4 lines, release 2, commit 2 more (data 0x50+i, 0x60+i) -> wr_line wraps to 2. Read rd_base=2, addr 1 -> rd_data0=0x51, rd_data1=0x61.
- Simultaneous eol+release at count=3 -> count stays 3, rd_line+1, wr_line+1. Release at count=0 -> ignored, empty stays 1.
- Illegal read: count=1, rd_en with rd_base=0 -> rd_valid=0 next cycle. clear asserted with wr_en+wr_eol -> count=0, wr_line=0, write dropped.
- Async reset mid-line: assert resetn=0 between clock edges while writing -> rd_valid, rd_data0/1 and lines_avail go to 0 immediately. After release of reset, a new line commits to line 0.
